// File: rtl/cmd_gen_pkg.sv
// Shared types and defaults for the Dealer command queue generator.
// Holds the FSM state encoding, default parameter values and the
// statistics counter width with its saturating-increment helper.
package cmd_gen_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SEND     = 2'd1,
    WAIT_ACK = 2'd2,
    GAP      = 2'd3
  } state_t;

  localparam int DEF_CMD_W       = 3;
  localparam int DEF_DEPTH       = 4;
  localparam int DEF_TIMEOUT_CYC = 16;
  localparam int DEF_MAX_RETRY   = 2;
  localparam int STAT_W          = 16;

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Purpose: synchronous FIFO for queued player commands.
// Latency: written data is visible on dout_o the cycle after the push edge.
// Backpressure: push ignored when full, pop ignored when empty; status is registered.
// Ports: push_i/din_i write side, pop_i/dout_o read side (show-ahead),
//        full_o/empty_o/count_o registered occupancy status.
module cmd_fifo #(
  parameter int WIDTH = 3,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       din_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       dout_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  // Full is judged on the registered count, so a push while full is
  // dropped even if a pop happens in the same cycle.
  assign do_push = push_i && (count_q != FULL_CNT);
  assign do_pop  = pop_i  && (count_q != '0);

  always_comb begin
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pointers are AW bits wide and wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  // Storage needs no reset; the count gates every read.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

  assign dout_o  = mem_q[rd_ptr_q];
  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

endmodule

// File: rtl/cmd_queue_generator.sv
// Purpose: queues player actions and issues them one at a time to the Dealer with ack timeout/retry.
// Latency: trigger into idle empty block -> cr_cmdvld two edges later; next command two edges after ack.
// Backpressure: trigger while q_full is dropped with a one-cycle overflow pulse.
// Ports: action_code/trigger push side; q_full/q_count/overflow queue status;
//        cr_cmd/cr_cmdvld/cr_ack Dealer handshake; cmd_done/cmd_err result pulses; idle.
// Optional: define CMD_QUEUE_STATS_EN to add stat_sent/stat_retry/stat_err saturating counters.
module cmd_queue_generator
  import cmd_gen_pkg::*;
#(
  parameter int CMD_W       = DEF_CMD_W,
  parameter int DEPTH       = DEF_DEPTH,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
  parameter int MAX_RETRY   = DEF_MAX_RETRY
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [CMD_W-1:0]       action_code,
  input  logic                   trigger,
  output logic                   q_full,
  output logic [$clog2(DEPTH):0] q_count,
  output logic                   overflow,
  output logic [CMD_W-1:0]       cr_cmd,
  output logic                   cr_cmdvld,
  input  logic                   cr_ack,
  output logic                   cmd_done,
  output logic                   cmd_err,
  output logic                   idle
`ifdef CMD_QUEUE_STATS_EN
  ,
  output logic [STAT_W-1:0]      stat_sent,
  output logic [STAT_W-1:0]      stat_retry,
  output logic [STAT_W-1:0]      stat_err
`endif
);

  localparam int TW = $clog2(TIMEOUT_CYC);
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [TW-1:0] TIMER_LAST  = TW'(TIMEOUT_CYC - 1);
  localparam logic [RW-1:0] MAX_RETRY_L = RW'(MAX_RETRY);

  state_t           state_q, state_d;
  logic [CMD_W-1:0] cmd_q, cmd_d;
  logic [RW-1:0]    retry_q, retry_d;
  logic [TW-1:0]    timer_q, timer_d;

  logic             fifo_pop, fifo_full, fifo_empty;
  logic [CMD_W-1:0] fifo_dout;
  logic             timeout;

  cmd_fifo #(
    .WIDTH (CMD_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (trigger),
    .din_i   (action_code),
    .pop_i   (fifo_pop),
    .dout_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (q_count)
  );

  assign timeout = (timer_q == TIMER_LAST);

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cmd_q   <= '0;
      retry_q <= '0;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      retry_q <= retry_d;
      timer_q <= timer_d;
    end
  end

  // Next state. cmd_q only loads in IDLE, so cr_cmd never moves while valid.
  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    retry_d = retry_q;
    timer_d = timer_q;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          cmd_d   = fifo_dout;
          retry_d = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        timer_d = '0;
        state_d = WAIT_ACK;
      end
      WAIT_ACK: begin
        timer_d = timer_q + 1'b1;
        // Ack takes priority over a timeout landing in the same cycle.
        if (cr_ack) begin
          state_d = IDLE;
        end else if (timeout) begin
          if (retry_q < MAX_RETRY_L) begin
            retry_d = retry_q + 1'b1;
            state_d = GAP;
          end else begin
            state_d = IDLE;
          end
        end
      end
      GAP:     state_d = SEND;
      default: state_d = IDLE;
    endcase
  end

  // Outputs.
  always_comb begin
    cr_cmdvld = (state_q == SEND) || (state_q == WAIT_ACK);
    cmd_done  = (state_q == WAIT_ACK) && cr_ack;
    cmd_err   = (state_q == WAIT_ACK) && !cr_ack && timeout && (retry_q >= MAX_RETRY_L);
    fifo_pop  = (state_q == IDLE) && !fifo_empty;
    idle      = (state_q == IDLE) && fifo_empty;
  end

  assign cr_cmd   = cmd_q;
  assign q_full   = fifo_full;
  assign overflow = trigger && fifo_full;

`ifdef CMD_QUEUE_STATS_EN
  logic [STAT_W-1:0] stat_sent_q, stat_retry_q, stat_err_q;

  // SEND and GAP are single-cycle states, so state_d equal to them marks entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_sent_q  <= '0;
      stat_retry_q <= '0;
      stat_err_q   <= '0;
    end else begin
      if (state_d == SEND) stat_sent_q  <= sat_inc(stat_sent_q);
      if (state_d == GAP)  stat_retry_q <= sat_inc(stat_retry_q);
      if (cmd_err)         stat_err_q   <= sat_inc(stat_err_q);
    end
  end

  assign stat_sent  = stat_sent_q;
  assign stat_retry = stat_retry_q;
  assign stat_err   = stat_err_q;
`endif

endmodule

// File: tb/tb_cmd_queue_generator.sv
// Self-checking bench for cmd_queue_generator with default parameters.
// The reference model tracks the pending queue and, for the command in flight,
// its position on the attempt timeline (SEND, TIMEOUT waits, GAP per attempt).
module tb_cmd_queue_generator;

  localparam int W  = 3;
  localparam int D  = 4;
  localparam int T  = 16;
  localparam int MR = 2;
  localparam int P  = T + 2;   // cycles per attempt including the gap

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] action_code = '0;
  logic         trigger = 1'b0;
  logic         q_full;
  logic [2:0]   q_count;
  logic         overflow;
  logic [W-1:0] cr_cmd;
  logic         cr_cmdvld;
  logic         cr_ack = 1'b0;
  logic         cmd_done;
  logic         cmd_err;
  logic         idle;
`ifdef CMD_QUEUE_STATS_EN
  logic [15:0]  stat_sent, stat_retry, stat_err;
`endif

  cmd_queue_generator #(
    .CMD_W (W), .DEPTH (D), .TIMEOUT_CYC (T), .MAX_RETRY (MR)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .action_code (action_code),
    .trigger     (trigger),
    .q_full      (q_full),
    .q_count     (q_count),
    .overflow    (overflow),
    .cr_cmd      (cr_cmd),
    .cr_cmdvld   (cr_cmdvld),
    .cr_ack      (cr_ack),
    .cmd_done    (cmd_done),
    .cmd_err     (cmd_err),
    .idle        (idle)
`ifdef CMD_QUEUE_STATS_EN
    ,
    .stat_sent   (stat_sent),
    .stat_retry  (stat_retry),
    .stat_err    (stat_err)
`endif
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  // Reference model state.
  logic [W-1:0] m_q[$];
  bit           m_busy;
  int           m_pos;
  logic [W-1:0] m_last;
  int           s_sent, s_retry, s_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_q.delete();
    m_busy = 0;
    m_pos  = 0;
    m_last = '0;
    s_sent = 0; s_retry = 0; s_err = 0;
  endtask

  function automatic bit in_ack_window();
    int ph;
    ph = m_pos % P;
    return m_busy && ph >= 1 && ph <= T;
  endfunction

  function automatic bit exp_err();
    return m_busy && !cr_ack && (m_pos % P) == T && (m_pos / P) == MR;
  endfunction

  task automatic check_outputs();
    bit full;
    full = (m_q.size() == D);
    chk("cr_cmdvld", cr_cmdvld, m_busy && (m_pos % P) != T + 1);
    chk("cmd_done",  cmd_done,  in_ack_window() && cr_ack);
    chk("cmd_err",   cmd_err,   exp_err());
    chk("cr_cmd",    cr_cmd,    m_last);
    chk("q_full",    q_full,    full);
    chk("q_count",   q_count,   m_q.size());
    chk("overflow",  overflow,  trigger && full);
    chk("idle",      idle,      !m_busy && m_q.size() == 0);
`ifdef CMD_QUEUE_STATS_EN
    chk("stat_sent",  stat_sent,  s_sent);
    chk("stat_retry", stat_retry, s_retry);
    chk("stat_err",   stat_err,   s_err);
`endif
  endtask

  // Advance the model across one rising edge using the inputs of that cycle.
  task automatic model_step();
    bit full_pre;
    int ph;
    full_pre = (m_q.size() == D);
    if (!m_busy) begin
      if (m_q.size() > 0) begin
        m_last = m_q.pop_front();
        m_busy = 1;
        m_pos  = 0;
        s_sent++;
      end
    end else begin
      ph = m_pos % P;
      if (in_ack_window() && cr_ack) begin
        m_busy = 0;
      end else if (exp_err()) begin
        m_busy = 0;
        s_err++;
      end else begin
        if (ph == T)     s_retry++;
        if (ph == T + 1) s_sent++;
        m_pos++;
      end
    end
    if (trigger && !full_pre) m_q.push_back(action_code);
  endtask

  // One clock cycle: drive, check at the falling edge, step the model at the rising edge.
  task automatic cyc(input bit trig, input logic [W-1:0] code, input int ack_at, input int ack_pct);
    trigger     = trig;
    action_code = code;
    cr_ack      = (m_busy && m_pos == ack_at) || ($urandom_range(99) < ack_pct);
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic run(input int n, input int ack_at);
    for (int i = 0; i < n; i++) cyc(1'b0, '0, ack_at, 0);
  endtask

  // Asynchronous reset asserted mid-cycle, checked while held, released off-edge.
  task automatic do_reset();
    trigger = 1'b0;
    cr_ack  = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs();
    @(posedge clk);
    @(negedge clk);
    check_outputs();
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    model_reset();
    // Power-on reset.
    #2;
    check_outputs();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    run(2, -1);

    // Single command, acked three cycles after valid rises.
    cyc(1'b1, 3'b101, -1, 0);
    run(10, 3);

    // Command in flight, then four queued and a fifth dropped on overflow.
    cyc(1'b1, 3'd7, -1, 0);
    cyc(1'b1, 3'd1, -1, 0);
    cyc(1'b1, 3'd2, -1, 0);
    cyc(1'b1, 3'd3, -1, 0);
    cyc(1'b1, 3'd4, 4, 0);
    cyc(1'b1, 3'd5, 4, 0);
    run(50, 2);

    // No ack at all: three attempts, then an error.
    do_reset();
    cyc(1'b1, 3'b010, -1, 0);
    run(3 * P + 4, -1);
`ifdef CMD_QUEUE_STATS_EN
    chk("retry_stat_sent",  stat_sent,  3);
    chk("retry_stat_retry", stat_retry, 2);
    chk("retry_stat_err",   stat_err,   1);
`endif

    // Ack on the second attempt, on the exact timeout cycle, and on the last attempt's timeout.
    cyc(1'b1, 3'b011, -1, 0);
    run(P + 10, P + 3);
    cyc(1'b1, 3'b110, -1, 0);
    run(T + 6, T);
    cyc(1'b1, 3'b001, -1, 0);
    run(3 * P + 4, MR * P + T);

    // Reset in WAIT_ACK with two entries queued.
    cyc(1'b1, 3'd6, -1, 0);
    cyc(1'b1, 3'd2, -1, 0);
    cyc(1'b1, 3'd3, -1, 0);
    run(4, -1);
    do_reset();
    run(30, -1);

    // Randomised traffic at several ack rates (random acks also land in SEND/GAP/IDLE).
    for (int blk = 0; blk < 3; blk++) begin
      int pct;
      pct = (blk == 0) ? 20 : (blk == 1) ? 3 : 60;
      for (int i = 0; i < 600; i++)
        cyc($urandom_range(99) < 30, W'($urandom_range(7)), -1, pct);
    end
    run(3 * P * (D + 1), -1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
